// File: rtl/uart_byte_tx.sv
// UART byte transmitter: one byte per start pulse, LSB first, 8N1 framing.
// Define UART_TX_PARITY_EN to insert an even-parity bit after D7 (8E1).
module uart_byte_tx #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_en,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_serial,
  output logic       o_tx_active,
  output logic       o_tx_done,
  output logic       o_overrun
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = 3;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(7);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            state, state_nxt;
  logic [BAUD_W-1:0] baud_cnt, baud_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_nxt;
  logic [7:0]        shift_reg, shift_nxt;
  logic              serial_nxt, active_nxt, done_nxt, overrun_nxt;
  logic              baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit, parity_nxt;
`endif

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // State and registered outputs; reset forces the line idle immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      o_tx_serial <= 1'b1;
      o_tx_active <= 1'b0;
      o_tx_done   <= 1'b0;
      o_overrun   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_nxt;
      bit_cnt     <= bit_nxt;
      shift_reg   <= shift_nxt;
      o_tx_serial <= serial_nxt;
      o_tx_active <= active_nxt;
      o_tx_done   <= done_nxt;
      o_overrun   <= overrun_nxt;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= parity_nxt;
`endif
    end
  end

  // Next-state, counters and next output values.
  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud_cnt;
    bit_nxt     = bit_cnt;
    shift_nxt   = shift_reg;
    overrun_nxt = o_overrun;
    done_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt  = parity_bit;
`endif

    if (state != IDLE) begin
      baud_nxt = baud_wrap ? '0 : BAUD_W'(baud_cnt + 1'b1);
      if (i_tx_en) overrun_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (i_tx_en) begin
          shift_nxt = i_tx_byte;
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = START;
`ifdef UART_TX_PARITY_EN
          parity_nxt = ^i_tx_byte;
`endif
        end
      end
      START: begin
        if (baud_wrap) state_nxt = DATA;
      end
      DATA: begin
        if (baud_wrap) begin
          shift_nxt = {1'b0, shift_reg[7:1]};
          if (bit_cnt == DATA_LAST) begin
            bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end else begin
            bit_nxt = BIT_W'(bit_cnt + 1'b1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) state_nxt = STOP;
      end
`endif
      STOP: begin
        // bit_cnt doubles as the stop-bit index here
        if (baud_wrap) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = BIT_W'(bit_cnt + 1'b1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    active_nxt = (state_nxt != IDLE);
    case (state_nxt)
      START:   serial_nxt = 1'b0;
      DATA:    serial_nxt = shift_nxt[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_nxt = parity_nxt;
`endif
      default: serial_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: two instances (4 clk/bit 1 stop, 5 clk/bit 2 stop)
// compared cycle by cycle against an arithmetic model of the frame.
module tb_uart_byte_tx;

  localparam int unsigned C0 = 4;
  localparam int unsigned S0 = 1;
  localparam int unsigned C1 = 5;
  localparam int unsigned S1 = 2;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned P = 1;
`else
  localparam int unsigned P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en   [2];
  logic [7:0] byt  [2];
  logic       ser  [2];
  logic       act  [2];
  logic       dn   [2];
  logic       ovr  [2];
  logic       ovr_exp [2];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  uart_byte_tx #(.CLKS_PER_BIT(C0), .STOP_BITS(S0)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(en[0]), .i_tx_byte(byt[0]),
    .o_tx_serial(ser[0]), .o_tx_active(act[0]), .o_tx_done(dn[0]), .o_overrun(ovr[0])
  );

  uart_byte_tx #(.CLKS_PER_BIT(C1), .STOP_BITS(S1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_en(en[1]), .i_tx_byte(byt[1]),
    .o_tx_serial(ser[1]), .o_tx_active(act[1]), .o_tx_done(dn[1]), .o_overrun(ovr[1])
  );

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned cpb(input bit sel);
    return sel ? C1 : C0;
  endfunction

  function automatic int unsigned flen(input bit sel);
    return (1 + 8 + P + (sel ? S1 : S0)) * cpb(sel);
  endfunction

  // Line level for bit slot k of a frame: start, D0..D7, [parity], stop(s).
  function automatic logic line_bit(input logic [7:0] b, input int unsigned k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return b[3'(k - 1)];
    else if (P == 1 && k == 9) return ^b;
    else return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input bit sel, input logic e_ser, input logic e_act,
                            input logic e_done, input string tag);
    string pfx;
    pfx = $sformatf("%s[u%0d]", tag, sel);
    check({pfx, "/serial"}, ser[sel], e_ser);
    check({pfx, "/active"}, act[sel], e_act);
    check({pfx, "/done"},   dn[sel],  e_done);
    check({pfx, "/overrun"}, ovr[sel], ovr_exp[sel]);
  endtask

  task automatic idle(input bit sel, input int unsigned n);
    en[sel] = 1'b0;
    repeat (n) begin
      step();
      check_outs(sel, 1'b1, 1'b0, 1'b0, "idle");
    end
  endtask

  // Sends b; optionally re-requests with 0xFF at frame cycle inj (0 = never).
  // Ends in the done cycle so a following send is back-to-back.
  task automatic send(input bit sel, input logic [7:0] b, input int unsigned inj);
    int unsigned c;
    int unsigned f;
    c = cpb(sel);
    f = flen(sel);
    en[sel]  = 1'b1;
    byt[sel] = b;
    step();
    for (int unsigned t = 1; t <= f + 1; t++) begin
      if (t <= f) check_outs(sel, line_bit(b, (t - 1) / c), 1'b1, 1'b0, "frame");
      else        check_outs(sel, 1'b1, 1'b0, 1'b1, "done");
      en[sel]  = (t == inj);
      byt[sel] = (t == inj) ? 8'hFF : 8'($urandom);
      if (t == inj) ovr_exp[sel] = 1'b1;
      if (t <= f) step();
    end
    en[sel] = 1'b0;
  endtask

  initial begin
    logic [7:0]  b;
    int unsigned inj;
    for (int i = 0; i < 2; i++) begin
      en[i] = 1'b0;
      byt[i] = 8'h00;
      ovr_exp[i] = 1'b0;
    end

    repeat (3) step();
    check_outs(1'b0, 1'b1, 1'b0, 1'b0, "reset");
    check_outs(1'b1, 1'b1, 1'b0, 1'b0, "reset");
    #2 rst_n = 1'b1;
    idle(1'b0, 3);

    send(1'b0, 8'hA5, 0);
    send(1'b0, 8'h3C, 0);
    idle(1'b0, 2);
    send(1'b0, 8'h5A, 10);
    idle(1'b0, 3);
    send(1'b0, 8'h07, 0);

    repeat (8) begin
      b   = 8'($urandom);
      inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, flen(1'b0) - 1) : 0;
      send(1'b0, b, inj);
      if ($urandom_range(0, 1) == 1) idle(1'b0, $urandom_range(1, 3));
    end

    idle(1'b1, 2);
    send(1'b1, 8'hC3, 0);
    repeat (5) begin
      b   = 8'($urandom);
      inj = ($urandom_range(0, 2) == 0) ? $urandom_range(1, flen(1'b1) - 1) : 0;
      send(1'b1, b, inj);
      if ($urandom_range(0, 1) == 1) idle(1'b1, 1);
    end

    // Abort a frame with reset mid-cycle; outputs must go idle at once.
    en[0]  = 1'b1;
    byt[0] = 8'h96;
    step();
    en[0] = 1'b0;
    repeat (4) step();
    check("pre_abort/serial", ser[0], line_bit(8'h96, 1));
    rst_n = 1'b0;
    ovr_exp[0] = 1'b0;
    ovr_exp[1] = 1'b0;
    #1;
    check_outs(1'b0, 1'b1, 1'b0, 1'b0, "abort");
    check_outs(1'b1, 1'b1, 1'b0, 1'b0, "abort");
    step();
    check_outs(1'b0, 1'b1, 1'b0, 1'b0, "in_reset");
    #2 rst_n = 1'b1;
    idle(1'b0, 6);
    send(1'b0, 8'($urandom), 0);
    idle(1'b0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
